blinking_led: RTL and testbench

Free-running LED blinker: divides the system clock by a programmable half-period and toggles a single LED output, producing a 50 % duty-cycle square wave. Sits at board top level and drives a status LED directly; no host interface. Default parameters give 1 Hz blinking (0.5 s on, 0.5 s off) from a 100 MHz clock.

---
 rtl/blinking_led.sv | 66 ++++++
 tb/tb_blinking_led.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/blinking_led.sv
// Free-running LED blinker: toggles led every HALF_PERIOD_CYCLES clocks.
// Define BLINKING_LED_RST_SYNC_EN to add a 2-flop reset release synchronizer.
module blinking_led #(
  parameter int unsigned HALF_PERIOD_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic led
);

  localparam int unsigned CNT_W =
    (HALF_PERIOD_CYCLES > 32'd1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(HALF_PERIOD_CYCLES - 32'd1);

  logic core_rst_n;

`ifdef BLINKING_LED_RST_SYNC_EN
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // assertion stays asynchronous, release is retimed to clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign core_rst_n = rst_sync_q[1];
`else
  assign core_rst_n = reset;
`endif

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             led_q;
  logic             led_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    led_d = led_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      led_d = ~led_q;
    end
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_blinking_led.sv
// Directed bench for blinking_led across several half-period settings.
// Covers baseline and BLINKING_LED_RST_SYNC_EN builds.
module tb_blinking_led;

`ifdef BLINKING_LED_RST_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk;
  logic rst_a;
  logic rst_b;
  logic rst_c;
  logic led4;
  logic led1;
  logic led5;
  logic led6;
  logic leddef;

  int total = 0;
  int bad = 0;

  blinking_led #(.HALF_PERIOD_CYCLES(4)) dut4 (
    .clk(clk), .reset(rst_a), .led(led4));
  blinking_led #(.HALF_PERIOD_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst_a), .led(led1));
  blinking_led dutdef (
    .clk(clk), .reset(rst_a), .led(leddef));
  blinking_led #(.HALF_PERIOD_CYCLES(6)) dut6 (
    .clk(clk), .reset(rst_b), .led(led6));
  blinking_led #(.HALF_PERIOD_CYCLES(5)) dut5 (
    .clk(clk), .reset(rst_c), .led(led5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int   edge_n;
    logic exp4;
    logic exp1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int trans;
    logic prev4;
    logic exp6;

    vecs[0] = '{1, 1'b0, 1'b1};
    vecs[1] = '{2, 1'b0, 1'b0};
    vecs[2] = '{3, 1'b0, 1'b1};
    vecs[3] = '{4, 1'b1, 1'b0};
    vecs[4] = '{5, 1'b1, 1'b1};
    vecs[5] = '{6, 1'b1, 1'b0};
    vecs[6] = '{7, 1'b1, 1'b1};
    vecs[7] = '{8, 1'b0, 1'b0};

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led4", led4, 0);
    check("rst_led1", led1, 0);
    check("rst_led6", led6, 0);
    check("rst_led5", led5, 0);
    check("rst_leddef", leddef, 0);

    // HALF=4 and HALF=1 from the vector table
    @(negedge clk);
    rst_a = 1'b1;
    repeat (SYNC) begin
      @(posedge clk);
      #1;
      check("sync_hold4", led4, 0);
    end
    trans = 0;
    prev4 = led4;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("h4_edge%0d", vecs[i].edge_n), led4, vecs[i].exp4);
      check($sformatf("h1_edge%0d", vecs[i].edge_n), led1, vecs[i].exp1);
      if (led4 !== prev4) trans++;
      prev4 = led4;
    end
    check("h4_transitions", trans, 2);

    repeat (100) @(posedge clk);
    #1;
    check("default_still_off", leddef, 0);

    // HALF=5: reset while led=1 and cnt=2
    @(negedge clk);
    rst_c = 1'b1;
    repeat (7 + SYNC) @(posedge clk);
    #1;
    check("h5_led_before", led5, 1);
    check("h5_cnt_before", dut5.cnt_q, 2);
    #1;
    rst_c = 1'b0;
    #1;
    check("h5_async_led", led5, 0);
    check("h5_async_cnt", dut5.cnt_q, 0);
    @(negedge clk);
    rst_c = 1'b1;
    for (int e = 1; e <= 5 + SYNC; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("h5_restart_edge%0d", e), led5,
            (e == 5 + SYNC) ? 1 : 0);
    end

    // HALF=6: ten full periods against a toggle model
    @(negedge clk);
    rst_b = 1'b1;
    for (int e = 1; e <= 120 + SYNC; e++) begin
      @(posedge clk);
      #1;
      exp6 = (e > SYNC) ? (((e - SYNC) / 6) % 2 == 1) : 1'b0;
      check($sformatf("h6_edge%0d", e), led6, exp6);
      check($sformatf("h6_cnt_max_edge%0d", e), dut6.cnt_q <= 3'd5, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
